// File: rtl/rv32_dmem_ctrl_if.sv
// Request/response bundle between the rv32 core MEM stage (master) and the data-memory controller (slave).
interface rv32_dmem_ctrl_if;
  logic        dmem_valid;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_valid, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    input  dmem_ready, dmem_rdata
  );

  modport slave (
    input  dmem_valid, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    output dmem_ready, dmem_rdata
  );
endinterface

// File: rtl/rv32_dmem_ctrl.sv
// Word-wide data RAM with byte strobes and sticky out-of-range flag; DMEM_STATS_EN adds load/store counters.
// Latency: ready pulses WAIT_STATES+1 cycles after acceptance; one access per WAIT_STATES+2 cycles.
// Backpressure: the request is held by the core until the single-cycle dmem_ready pulse.
module rv32_dmem_ctrl #(
  parameter int    DEPTH_WORDS = 1024,
  parameter int    WAIT_STATES = 1,
  parameter string INIT_FILE   = ""
) (
  input  logic             clk,
  input  logic             rst_n,
  rv32_dmem_ctrl_if.slave  dmem,
  output logic             err_oor,
  input  logic             err_clr
`ifdef DMEM_STATS_EN
  ,
  output logic [31:0]      rd_count,
  output logic [31:0]      wr_count
`endif
);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t        state, state_nxt;
  logic [3:0]    cnt, cnt_nxt;
  logic          accept;

  logic          req_we;
  logic [31:2]   req_addr;
  logic [31:0]   req_wdata;
  logic [3:0]    req_wstrb;

  logic [31:0]   mem [DEPTH_WORDS];

  logic          cur_we;
  logic [31:2]   cur_addr;
  logic          cur_oor;
  logic [AW-1:0] cur_idx;
  logic          rd_en;
  logic          req_oor;
  logic [AW-1:0] req_idx;
  logic          unused_addr_lsb;

  assign unused_addr_lsb = ^dmem.dmem_addr[1:0];

  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    accept          = 1'b0;
    dmem.dmem_ready = 1'b0;
    case (state)
      S_IDLE: begin
        if (dmem.dmem_valid) begin
          accept = 1'b1;
          if (WAIT_STATES > 0) begin
            state_nxt = S_WAIT;
            cnt_nxt   = 4'(WAIT_STATES - 1);
          end else begin
            state_nxt = S_RESP;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) state_nxt = S_RESP;
        else             cnt_nxt   = cnt - 4'd1;
      end
      S_RESP: begin
        dmem.dmem_ready = 1'b1;
        state_nxt       = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Read happens on the edge entering RESP; in IDLE the request is not latched yet, so use the live bus.
  assign cur_we   = (state == S_IDLE) ? dmem.dmem_we         : req_we;
  assign cur_addr = (state == S_IDLE) ? dmem.dmem_addr[31:2] : req_addr;
  assign cur_oor  = |cur_addr[31:AW+2];
  assign cur_idx  = cur_addr[AW+1:2];
  assign rd_en    = (state_nxt == S_RESP) && !cur_we;

  assign req_oor  = |req_addr[31:AW+2];
  assign req_idx  = req_addr[AW+1:2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      cnt             <= 4'd0;
      req_we          <= 1'b0;
      req_addr        <= '0;
      req_wdata       <= '0;
      req_wstrb       <= '0;
      dmem.dmem_rdata <= '0;
      err_oor         <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        req_we    <= dmem.dmem_we;
        req_addr  <= dmem.dmem_addr[31:2];
        req_wdata <= dmem.dmem_wdata;
        req_wstrb <= dmem.dmem_wstrb;
      end
      if (rd_en) dmem.dmem_rdata <= cur_oor ? 32'd0 : mem[cur_idx];
      if (state == S_RESP && req_oor) err_oor <= 1'b1;
      else if (err_clr)               err_oor <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_RESP && req_we && !req_oor) begin
      for (int k = 0; k < 4; k++) begin
        if (req_wstrb[k]) mem[req_idx][8*k +: 8] <= req_wdata[8*k +: 8];
      end
    end
  end

`ifdef DMEM_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_count <= 32'd0;
      wr_count <= 32'd0;
    end else if (err_clr) begin
      rd_count <= 32'd0;
      wr_count <= 32'd0;
    end else if (state == S_RESP && !req_oor) begin
      if (req_we) wr_count <= wr_count + 32'd1;
      else        rd_count <= rd_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rv32_dmem_ctrl.sv
// Directed plus random bench for rv32_dmem_ctrl: WAIT_STATES=1 instance against a word-array model, WAIT_STATES=0 instance for throughput.
module tb_rv32_dmem_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic a_err_clr, a_err_oor;
  logic b_err_clr, b_err_oor;

  rv32_dmem_ctrl_if a_if ();
  rv32_dmem_ctrl_if b_if ();

`ifdef DMEM_STATS_EN
  logic [31:0] a_rd_cnt, a_wr_cnt, b_rd_cnt, b_wr_cnt;
`endif

  rv32_dmem_ctrl #(.DEPTH_WORDS(1024), .WAIT_STATES(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .dmem(a_if.slave),
    .err_oor(a_err_oor), .err_clr(a_err_clr)
`ifdef DMEM_STATS_EN
    , .rd_count(a_rd_cnt), .wr_count(a_wr_cnt)
`endif
  );

  rv32_dmem_ctrl #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .dmem(b_if.slave),
    .err_oor(b_err_oor), .err_clr(b_err_clr)
`ifdef DMEM_STATS_EN
    , .rd_count(b_rd_cnt), .wr_count(b_wr_cnt)
`endif
  );

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: plain word array plus the observable side state.
  logic [31:0] model_mem [1024];
  logic [31:0] last_rd;
  logic        exp_err;
  int unsigned exp_rd_cnt, exp_wr_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input string tag, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wstrb);
    logic [31:0] exp_data, got_data;
    int          lat;
    bit          in_range;
    in_range = (addr < 32'd4096);
    if (!we) begin
      exp_data = in_range ? model_mem[addr[11:2]] : 32'd0;
      last_rd  = exp_data;
    end else begin
      exp_data = last_rd;
      if (in_range)
        for (int k = 0; k < 4; k++)
          if (wstrb[k]) model_mem[addr[11:2]][8*k +: 8] = wdata[8*k +: 8];
    end
    if (!in_range) exp_err = 1'b1;
    if (a_err_clr) begin
      exp_rd_cnt = 0;
      exp_wr_cnt = 0;
    end else if (in_range) begin
      if (we) exp_wr_cnt++;
      else    exp_rd_cnt++;
    end

    @(negedge clk);
    a_if.dmem_valid = 1'b1;
    a_if.dmem_we    = we;
    a_if.dmem_addr  = addr;
    a_if.dmem_wdata = wdata;
    a_if.dmem_wstrb = wstrb;
    lat      = 0;
    got_data = 32'hx;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (a_if.dmem_ready) begin
        lat      = i;
        got_data = a_if.dmem_rdata;
        break;
      end
    end
    a_if.dmem_valid = 1'b0;
    a_if.dmem_we    = $urandom_range(0, 1);
    a_if.dmem_addr  = $urandom;
    @(posedge clk); #1;
    check({tag, " latency"}, lat, 2);
    check({tag, " rdata"}, got_data, exp_data);
    check({tag, " ready_single"}, a_if.dmem_ready, 1'b0);
    check({tag, " err_oor"}, a_err_oor, exp_err);
`ifdef DMEM_STATS_EN
    check({tag, " rd_count"}, a_rd_cnt, exp_rd_cnt);
    check({tag, " wr_count"}, a_wr_cnt, exp_wr_cnt);
`endif
  endtask

  task automatic clr_pulse();
    @(negedge clk);
    a_err_clr = 1'b1;
    @(posedge clk); #1;
    a_err_clr = 1'b0;
    exp_err    = 1'b0;
    exp_rd_cnt = 0;
    exp_wr_cnt = 0;
    check("err_clr", a_err_oor, 1'b0);
  endtask

  initial begin
    logic [31:0] addr;
    int          pulses;
    rst_n = 1'b0;
    a_err_clr = 1'b0; b_err_clr = 1'b0;
    a_if.dmem_valid = 1'b0; a_if.dmem_we = 1'b0; a_if.dmem_addr = '0;
    a_if.dmem_wdata = '0;   a_if.dmem_wstrb = '0;
    b_if.dmem_valid = 1'b0; b_if.dmem_we = 1'b0; b_if.dmem_addr = '0;
    b_if.dmem_wdata = '0;   b_if.dmem_wstrb = '0;
    last_rd = 32'd0; exp_err = 1'b0; exp_rd_cnt = 0; exp_wr_cnt = 0;

    repeat (2) @(posedge clk);
    #1;
    check("reset ready", a_if.dmem_ready, 1'b0);
    check("reset rdata", a_if.dmem_rdata, 32'd0);
    check("reset err_oor", a_err_oor, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op("store_full", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    do_op("load_full", 1'b0, 32'h10, 32'h0, 4'h0);
    do_op("store_partial", 1'b1, 32'h10, 32'h0000AA00, 4'b0010);
    do_op("load_partial", 1'b0, 32'h10, 32'h0, 4'h0);
    do_op("store_w0", 1'b1, 32'h0, 32'h12345678, 4'hF);
    do_op("store_nostrb", 1'b1, 32'h14, 32'hFFFFFFFF, 4'h0);
    do_op("load_oor", 1'b0, 32'h0001_0000, 32'h0, 4'h0);
    clr_pulse();
    do_op("store_oor", 1'b1, 32'h0001_0000, 32'hFFFFFFFF, 4'hF);
    do_op("load_w0_after_oor", 1'b0, 32'h0, 32'h0, 4'h0);
    clr_pulse();

    // err_clr held through the RESP edge of an out-of-range access: the new error must survive.
    @(negedge clk);
    a_err_clr = 1'b1;
    do_op("set_wins", 1'b0, 32'hFFFF_FFF0, 32'h0, 4'h0);
    a_err_clr = 1'b0;
    clr_pulse();

`ifdef DMEM_STATS_EN
    do_op("stats_ld1", 1'b0, 32'h10, 32'h0, 4'h0);
    do_op("stats_ld2", 1'b0, 32'h0, 32'h0, 4'h0);
    do_op("stats_st", 1'b1, 32'h0, 32'h87654321, 4'hF);
    do_op("stats_st_oor", 1'b1, 32'h0002_0000, 32'h1, 4'hF);
    check("stats rd_count=2", a_rd_cnt, 32'd2);
    check("stats wr_count=1", a_wr_cnt, 32'd1);
    clr_pulse();
`endif

    // Reset asserted while the store sits in WAIT: no write, outputs cleared at once.
    do_op("load_before_rst", 1'b0, 32'h10, 32'h0, 4'h0);
    @(negedge clk);
    a_if.dmem_valid = 1'b1; a_if.dmem_we = 1'b1; a_if.dmem_addr = 32'h10;
    a_if.dmem_wdata = 32'h11223344; a_if.dmem_wstrb = 4'hF;
    @(posedge clk); #1;
    check("in_wait ready", a_if.dmem_ready, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rst_in_wait ready", a_if.dmem_ready, 1'b0);
    check("rst_in_wait rdata", a_if.dmem_rdata, 32'd0);
    a_if.dmem_valid = 1'b0;
    last_rd = 32'd0; exp_err = 1'b0; exp_rd_cnt = 0; exp_wr_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    do_op("load_after_rst", 1'b0, 32'h10, 32'h0, 4'h0);

    for (int i = 0; i < 16; i++)
      do_op("rand_fill", 1'b1, 32'h100 + 32'(4 * i), $urandom, 4'hF);
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 7) == 0) addr = $urandom | 32'h0000_1000;
      else addr = 32'h100 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
      do_op("rand_op", 1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom_range(0, 15)));
      if (exp_err && $urandom_range(0, 1) == 1) clr_pulse();
    end

    // WAIT_STATES=0 instance: single-cycle latency and one pulse per access with valid held.
    @(negedge clk);
    b_if.dmem_valid = 1'b1; b_if.dmem_we = 1'b1; b_if.dmem_addr = 32'h20;
    b_if.dmem_wdata = 32'hCAFEF00D; b_if.dmem_wstrb = 4'hF;
    @(posedge clk); #1;
    check("ws0 store ready", b_if.dmem_ready, 1'b1);
    b_if.dmem_valid = 1'b0;
    @(posedge clk); #1;
    check("ws0 store ready_single", b_if.dmem_ready, 1'b0);
    @(negedge clk);
    b_if.dmem_valid = 1'b1; b_if.dmem_we = 1'b0;
    pulses = 0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      check("ws0 held ready", b_if.dmem_ready, (k % 2 == 1) ? 1'b1 : 1'b0);
      if (b_if.dmem_ready) begin
        pulses++;
        check("ws0 held rdata", b_if.dmem_rdata, 32'hCAFEF00D);
      end
      if (k == 5) b_if.dmem_valid = 1'b0;
    end
    check("ws0 pulse count", pulses, 3);
    check("ws0 err_oor", b_err_oor, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end
endmodule
